// File: rtl/mul_err_eval_ctrl.sv
// mul_err_eval_ctrl
// Error-characterisation sequencer for an external 8x8 approximate multiplier.
// Each sample:
//   1. Present an LFSR-generated operand pair.
//   2. Wait a fixed settle time.
//   3. Compare the returned product against the exact product.
//   4. Accumulate error count, sum and max of the absolute error distance.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   start       run request, honoured in IDLE or DONE only
//   busy        high in LOAD/WAIT/EVAL
//   done        high in DONE, held until start or rst
//   mul_a/mul_b registered operands to the multiplier under test
//   mul_p       product returned by the multiplier under test
//   sample_cnt  samples evaluated this run
//   err_cnt     samples whose product differed from exact
//   sum_aed     saturating sum of |exact - mul_p|
//   max_aed     largest |exact - mul_p| this run
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | drive next operand pair, arm settle timer
// WAIT   | settle timer counting down to 1
// EVAL   | sample mul_p, update accumulators, step LFSR
// DONE   | run complete, results final, waiting for start
module mul_err_eval_ctrl #(
  parameter int unsigned N_SAMPLES = 10000,
  parameter int unsigned SETTLE    = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic [15:0] sample_cnt,
  output logic [15:0] err_cnt,
  output logic [31:0] sum_aed,
  output logic [15:0] max_aed
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] N_LAST    = 16'(N_SAMPLES);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [7:0]  wait_cnt;
  logic [15:0] exact;
  logic [15:0] aed;
  logic [32:0] sum_ext;
  logic [15:0] sample_inc;

  assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign exact      = {8'h00, mul_a} * {8'h00, mul_b};
  assign aed        = (exact >= mul_p) ? (exact - mul_p) : (mul_p - exact);
  assign sum_ext    = {1'b0, sum_aed} + {17'h0, aed};
  assign sample_inc = sample_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == 8'd1) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        busy      = 1'b1;
        state_nxt = (sample_inc == N_LAST) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED_EFF;
      wait_cnt   <= 8'd0;
      mul_a      <= 8'd0;
      mul_b      <= 8'd0;
      sample_cnt <= 16'd0;
      err_cnt    <= 16'd0;
      sum_aed    <= 32'd0;
      max_aed    <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr       <= SEED_EFF;
            sample_cnt <= 16'd0;
            err_cnt    <= 16'd0;
            sum_aed    <= 32'd0;
            max_aed    <= 16'd0;
          end
        end
        S_LOAD: begin
          mul_a    <= lfsr[15:8];
          mul_b    <= lfsr[7:0];
          wait_cnt <= SETTLE_LD;
        end
        S_WAIT: wait_cnt <= wait_cnt - 8'd1;
        S_EVAL: begin
          sample_cnt <= sample_inc;
          if (aed != 16'd0) err_cnt <= err_cnt + 16'd1;
          sum_aed <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
          if (aed > max_aed) max_aed <= aed;
          lfsr <= lfsr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_err_eval_ctrl.sv
// Bench for mul_err_eval_ctrl. Five instances cover the different
// multiplier models and parameter sets:
//   0 exact multiplier
//   1 product tied to zero
//   2 two LSBs truncated
//   3 product valid four cycles after operand change, SETTLE=4
//   4 same late-valid model, SETTLE=3
// Expected totals per run and the operand sequence of instance 2 are
// queued when a run is started and compared as the DUT produces them.
module tb_mul_err_eval_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r   [5];
  logic        start_r [5];
  logic        busy_w  [5];
  logic        done_w  [5];
  logic [7:0]  a_w     [5];
  logic [7:0]  b_w     [5];
  logic [15:0] p_w     [5];
  logic [15:0] sc_w    [5];
  logic [15:0] ec_w    [5];
  logic [31:0] sum_w   [5];
  logic [15:0] mx_w    [5];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] sc;
    logic [15:0] ec;
    logic [31:0] sum;
    logic [15:0] mx;
  } tot_t;

  tot_t        tot_q[$];
  logic [15:0] op_q[$];
  logic [15:0] prev_ab [5];
  int          age     [5];

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    return {8'h00, a} * {8'h00, b};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic tot_t model_run(input logic [15:0] seed, input int n, input int mode);
    tot_t        t;
    logic [15:0] l, ex, p, d;
    logic [32:0] s;
    t = '0;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < n; k++) begin
      ex = prod(l[15:8], l[7:0]);
      case (mode)
        0:       p = ex;
        1:       p = 16'h0000;
        2:       p = ex & 16'hFFFC;
        default: p = ~ex;
      endcase
      d    = (ex >= p) ? ex - p : p - ex;
      t.sc = t.sc + 16'd1;
      if (d != 16'd0) t.ec = t.ec + 16'd1;
      s     = {1'b0, t.sum} + {17'h0, d};
      t.sum = s[32] ? 32'hFFFF_FFFF : s[31:0];
      if (d > t.mx) t.mx = d;
      l = lfsr_step(l);
    end
    return t;
  endfunction

  task automatic push_ops(input logic [15:0] seed, input int n);
    logic [15:0] l;
    l = seed;
    for (int k = 0; k < n; k++) begin
      op_q.push_back(l);
      l = lfsr_step(l);
    end
  endtask

  // Late-valid multiplier: age counts edges since the operands last changed.
  always @(posedge clk) begin
    for (int i = 3; i < 5; i++) begin
      if (rst_r[i]) begin
        prev_ab[i] <= 16'h0000;
        age[i]     <= 0;
      end else if ({a_w[i], b_w[i]} != prev_ab[i]) begin
        prev_ab[i] <= {a_w[i], b_w[i]};
        age[i]     <= 1;
      end else if (age[i] < 1000) begin
        age[i] <= age[i] + 1;
      end
    end
  end

  always_comb begin
    p_w[0] = prod(a_w[0], b_w[0]);
    p_w[1] = 16'h0000;
    p_w[2] = prod(a_w[2], b_w[2]) & 16'hFFFC;
    for (int i = 3; i < 5; i++)
      p_w[i] = (age[i] >= 4) ? prod(a_w[i], b_w[i]) : ~prod(a_w[i], b_w[i]);
  end

  mul_err_eval_ctrl #(.N_SAMPLES(16), .SETTLE(2), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .mul_a(a_w[0]), .mul_b(b_w[0]), .mul_p(p_w[0]), .sample_cnt(sc_w[0]),
    .err_cnt(ec_w[0]), .sum_aed(sum_w[0]), .max_aed(mx_w[0]));

  mul_err_eval_ctrl #(.N_SAMPLES(1), .SETTLE(4), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .mul_a(a_w[1]), .mul_b(b_w[1]), .mul_p(p_w[1]), .sample_cnt(sc_w[1]),
    .err_cnt(ec_w[1]), .sum_aed(sum_w[1]), .max_aed(mx_w[1]));

  mul_err_eval_ctrl #(.N_SAMPLES(5000), .SETTLE(2), .SEED(16'hACE1)) u_dut2 (
    .clk(clk), .rst(rst_r[2]), .start(start_r[2]), .busy(busy_w[2]), .done(done_w[2]),
    .mul_a(a_w[2]), .mul_b(b_w[2]), .mul_p(p_w[2]), .sample_cnt(sc_w[2]),
    .err_cnt(ec_w[2]), .sum_aed(sum_w[2]), .max_aed(mx_w[2]));

  mul_err_eval_ctrl #(.N_SAMPLES(32), .SETTLE(4), .SEED(16'hACE1)) u_dut3 (
    .clk(clk), .rst(rst_r[3]), .start(start_r[3]), .busy(busy_w[3]), .done(done_w[3]),
    .mul_a(a_w[3]), .mul_b(b_w[3]), .mul_p(p_w[3]), .sample_cnt(sc_w[3]),
    .err_cnt(ec_w[3]), .sum_aed(sum_w[3]), .max_aed(mx_w[3]));

  mul_err_eval_ctrl #(.N_SAMPLES(32), .SETTLE(3), .SEED(16'hACE1)) u_dut4 (
    .clk(clk), .rst(rst_r[4]), .start(start_r[4]), .busy(busy_w[4]), .done(done_w[4]),
    .mul_a(a_w[4]), .mul_b(b_w[4]), .mul_p(p_w[4]), .sample_cnt(sc_w[4]),
    .err_cnt(ec_w[4]), .sum_aed(sum_w[4]), .max_aed(mx_w[4]));

  task automatic check_zero(input int idx);
    check_val("zero_busy", busy_w[idx], 0);
    check_val("zero_done", done_w[idx], 0);
    check_val("zero_mul_a", a_w[idx], 0);
    check_val("zero_mul_b", b_w[idx], 0);
    check_val("zero_sample_cnt", sc_w[idx], 0);
    check_val("zero_err_cnt", ec_w[idx], 0);
    check_val("zero_sum_aed", sum_w[idx], 0);
    check_val("zero_max_aed", mx_w[idx], 0);
  endtask

  // One full run: queue expectations, pulse start, follow the run to done.
  // noisy pulses start repeatedly while busy; ops checks every operand pair.
  task automatic run_once(input int idx, input int n, input int settle, input int mode,
                          input bit noisy, input bit ops);
    tot_t        exp;
    int          cyc;
    logic [15:0] prev_sc;
    tot_q.push_back(model_run(16'hACE1, n, mode));
    if (ops) begin
      op_q.delete();
      push_ops(16'hACE1, n);
    end
    @(negedge clk);
    start_r[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_r[idx] = 1'b0;
    check_val("busy_after_start", busy_w[idx], 1);
    check_val("done_after_start", done_w[idx], 0);
    prev_sc = sc_w[idx];
    cyc     = 0;
    for (int k = 1; k <= n * (settle + 2) + 20; k++) begin
      @(posedge clk);
      #1;
      if (ops && sc_w[idx] == prev_sc + 16'd1) begin
        if (op_q.size() == 0) check_val("op_sb_empty", 1, 0);
        else                  check_val("op_pair", {a_w[idx], b_w[idx]}, op_q.pop_front());
      end
      prev_sc = sc_w[idx];
      if (done_w[idx]) begin
        cyc = k;
        break;
      end
      start_r[idx] = noisy && (k % 7 == 3);
    end
    start_r[idx] = 1'b0;
    check_val("done_latency", cyc, n * (settle + 2));
    check_val("busy_in_done", busy_w[idx], 0);
    if (tot_q.size() == 0) begin
      check_val("tot_sb_empty", 1, 0);
    end else begin
      exp = tot_q.pop_front();
      check_val("sample_cnt", sc_w[idx], exp.sc);
      check_val("err_cnt", ec_w[idx], exp.ec);
      check_val("sum_aed", sum_w[idx], exp.sum);
      check_val("max_aed", mx_w[idx], exp.mx);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      rst_r[i]   = 1'b1;
      start_r[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) check_zero(i);
    @(negedge clk);
    for (int i = 0; i < 5; i++) rst_r[i] = 1'b0;

    // exact multiplier, then restart from DONE with start noise while busy
    run_once(0, 16, 2, 0, 1'b0, 1'b0);
    run_once(0, 16, 2, 0, 1'b1, 1'b0);

    // product tied to zero, single sample
    run_once(1, 1, 4, 1, 1'b0, 1'b0);
    check_val("t2_mul_a", a_w[1], 172);
    check_val("t2_mul_b", b_w[1], 225);
    check_val("t2_sum_aed", sum_w[1], 38700);
    check_val("t2_max_aed", mx_w[1], 38700);

    // truncated multiplier, long run
    run_once(2, 5000, 2, 2, 1'b0, 1'b1);
    check_val("t3_max_le3", (mx_w[2] <= 16'd3), 1);

    // abort during WAIT of sample 5 with start also asserted
    @(negedge clk);
    start_r[2] = 1'b1;
    @(posedge clk);
    #1;
    start_r[2] = 1'b0;
    for (int k = 0; k < 200 && sc_w[2] != 16'd4; k++) begin
      @(posedge clk);
      #1;
    end
    check_val("abort_reach_s4", sc_w[2], 4);
    @(posedge clk);
    #1;
    check_val("abort_busy_wait", busy_w[2], 1);
    rst_r[2]   = 1'b1;
    start_r[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_r[2]   = 1'b0;
    start_r[2] = 1'b0;
    check_zero(2);
    @(posedge clk);
    #1;
    check_val("idle_after_abort", busy_w[2], 0);
    run_once(2, 5000, 2, 2, 1'b0, 1'b1);

    // late-valid product: enough settle, then one cycle short
    run_once(3, 32, 4, 0, 1'b0, 1'b0);
    run_once(4, 32, 3, 3, 1'b0, 1'b0);
    check_val("t6_err_pos", (ec_w[4] > 16'd0), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
